// File: rtl/xornor_bscan_array.sv
// -----------------------------------------------------------------------------
// xornor_bscan_array
//
// A WIDTH-wide bank of XOR/NOR slices (X = A^B, Y = ~(X|C)) with a one-cycle
// registered core. Every pin has a boundary-scan cell. The cells form one serial
// chain, which the TAP controller's DR strobes operate.
//
// Parameters:
//   WIDTH      number of slices; the scan chain is 5*WIDTH cells long.
//
// Ports:
//   Clk        rising-edge clock for all state
//   Reset      synchronous, active-high reset (clears SR, UR, core, bypass)
//   A, B, C    functional data pins                               [WIDTH]
//   X, Y       functional results                                 [WIDTH]
//   Mode       0 = normal, 1 = test (core inputs and X/Y come from UR)
//   CaptureDR  load pins and core results into the shift register
//   ShiftDR    shift the chain one cell toward ScanOut
//   UpdateDR   copy the shift register into the update register
//   ScanIn     serial chain input
//   ScanOut    serial chain output (SR MSB, or BR while bypassed)
//   Bypass     present only when XORNOR_BSCAN_BYPASS_EN is defined
//
// Cell map (the same for SR and UR):
//   [W-1:0]=A  [2W-1:W]=B  [3W-1:2W]=C  [4W-1:3W]=X  [5W-1:4W]=Y
//
// Build option:
//   XORNOR_BSCAN_BYPASS_EN  adds the Bypass port and a 1-bit bypass register.
//                           While Bypass=1 the chain is BR alone, and SR and UR
//                           hold.
// -----------------------------------------------------------------------------
module xornor_bscan_array #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  input  logic             Mode,
  input  logic             CaptureDR,
  input  logic             ShiftDR,
  input  logic             UpdateDR,
`ifdef XORNOR_BSCAN_BYPASS_EN
  input  logic             Bypass,
`endif
  input  logic             ScanIn,
  output logic             ScanOut
);

  localparam int N = 5 * WIDTH;

  logic [N-1:0]     sr_r;
  logic [N-1:0]     ur_r;
  logic [WIDTH-1:0] xr_r;
  logic [WIDTH-1:0] yr_r;

  logic [N-1:0]     sr_next_s;
  logic [N-1:0]     ur_next_s;
  logic [N-1:0]     capture_s;
  logic [WIDTH-1:0] ain_s;
  logic [WIDTH-1:0] bin_s;
  logic [WIDTH-1:0] cin_s;
  logic [WIDTH-1:0] xor_s;
  logic             bypass_active_s;

`ifdef XORNOR_BSCAN_BYPASS_EN
  logic             br_r;
  logic             br_next_s;

  assign bypass_active_s = Bypass;
`else
  assign bypass_active_s = 1'b0;
`endif

  // Core input select: pins in normal mode, UR A/B/C fields in test mode.
  always_comb begin
    ain_s = A;
    bin_s = B;
    cin_s = C;
    if (Mode) begin
      ain_s = ur_r[WIDTH-1:0];
      bin_s = ur_r[2*WIDTH-1:WIDTH];
      cin_s = ur_r[3*WIDTH-1:2*WIDTH];
    end else begin
      ain_s = A;
      bin_s = B;
      cin_s = C;
    end
  end

  assign xor_s = ain_s ^ bin_s;

  // Capture always samples the pins, even in test mode. The X/Y cells take the
  // registered core, which is the result of the previous cycle.
  assign capture_s = {yr_r, xr_r, C, B, A};

  // Shift/update register next state. Capture has priority over shift, and
  // update is independent of both. A bypassed chain freezes SR and UR.
  always_comb begin
    sr_next_s = sr_r;
    ur_next_s = ur_r;
    if (bypass_active_s) begin
      sr_next_s = sr_r;
      ur_next_s = ur_r;
    end else begin
      if (CaptureDR) begin
        sr_next_s = capture_s;
      end else if (ShiftDR) begin
        sr_next_s = {sr_r[N-2:0], ScanIn};
      end else begin
        sr_next_s = sr_r;
      end
      // UR takes the pre-edge SR, so a same-cycle capture/shift is not seen.
      if (UpdateDR) begin
        ur_next_s = sr_r;
      end else begin
        ur_next_s = ur_r;
      end
    end
  end

  // Scan chain, update register and core result registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sr_r <= {N{1'b0}};
      ur_r <= {N{1'b0}};
      xr_r <= {WIDTH{1'b0}};
      yr_r <= {WIDTH{1'b0}};
    end else begin
      sr_r <= sr_next_s;
      ur_r <= ur_next_s;
      xr_r <= xor_s;
      yr_r <= ~(xor_s | cin_s);
    end
  end

`ifdef XORNOR_BSCAN_BYPASS_EN
  // Bypass register next state: capture clears it, shift loads ScanIn.
  always_comb begin
    br_next_s = br_r;
    if (Bypass) begin
      if (CaptureDR) begin
        br_next_s = 1'b0;
      end else if (ShiftDR) begin
        br_next_s = ScanIn;
      end else begin
        br_next_s = br_r;
      end
    end else begin
      br_next_s = br_r;
    end
  end

  // One-bit bypass register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      br_r <= 1'b0;
    end else begin
      br_r <= br_next_s;
    end
  end

  // Serial output: BR while bypassed, otherwise the SR MSB.
  always_comb begin
    ScanOut = sr_r[N-1];
    if (Bypass) begin
      ScanOut = br_r;
    end else begin
      ScanOut = sr_r[N-1];
    end
  end
`else
  // Serial output is the SR MSB, so it changes only on the clock edge.
  always_comb begin
    ScanOut = sr_r[N-1];
  end
`endif

  // Output mux. Mode acts combinationally and adds no latency.
  always_comb begin
    X = xr_r;
    Y = yr_r;
    if (Mode) begin
      X = ur_r[4*WIDTH-1:3*WIDTH];
      Y = ur_r[5*WIDTH-1:4*WIDTH];
    end else begin
      X = xr_r;
      Y = yr_r;
    end
  end

endmodule

// File: tb/tb_xornor_bscan_array.sv
// -----------------------------------------------------------------------------
// Self-checking bench for xornor_bscan_array (WIDTH=4, 20-cell chain).
// A behavioural model holds the chain as a bit queue (front = ScanOut end).
// The model steps on each rising edge. A compare process checks X, Y and
// ScanOut on every falling edge. Directed steps pin the model to
// hand-computed literal values, and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_xornor_bscan_array;

  localparam int W = 4;
  localparam int N = 5 * W;
`ifdef XORNOR_BSCAN_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset;
  logic [W-1:0] A, B, C, X, Y;
  logic         Mode, CaptureDR, ShiftDR, UpdateDR, ScanIn, ScanOut;
  logic         bypass;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 Clk = ~Clk;

  xornor_bscan_array #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .A         (A),
    .B         (B),
    .C         (C),
    .X         (X),
    .Y         (Y),
    .Mode      (Mode),
    .CaptureDR (CaptureDR),
    .ShiftDR   (ShiftDR),
    .UpdateDR  (UpdateDR),
`ifdef XORNOR_BSCAN_BYPASS_EN
    .Bypass    (bypass),
`endif
    .ScanIn    (ScanIn),
    .ScanOut   (ScanOut)
  );

  // ---------------- behavioural model ----------------
  bit           m_chain[$];
  logic [N-1:0] m_ur;
  logic [W-1:0] m_xr, m_yr, m_a, m_b, m_c;
  logic         m_br;
  logic [N-1:0] m_sr_old;

  function automatic logic [N-1:0] pack_chain();
    logic [N-1:0] v;
    v = {N{1'b0}};
    for (int i = 0; i < N; i++) v[N-1-i] = m_chain[i];
    return v;
  endfunction

  task automatic load_chain(input logic [N-1:0] v);
    m_chain.delete();
    for (int i = N - 1; i >= 0; i--) m_chain.push_back(v[i]);
  endtask

  initial load_chain({N{1'b0}});

  always @(posedge Clk) begin
    m_sr_old = pack_chain();
    if (Reset) begin
      load_chain({N{1'b0}});
      m_ur = {N{1'b0}};
      m_xr = {W{1'b0}};
      m_yr = {W{1'b0}};
      m_br = 1'b0;
    end else begin
      if (Mode) begin
        m_a = m_ur[W-1:0];
        m_b = m_ur[2*W-1:W];
        m_c = m_ur[3*W-1:2*W];
      end else begin
        m_a = A;
        m_b = B;
        m_c = C;
      end
      if (BYP_EN && bypass) begin
        if (CaptureDR) m_br = 1'b0;
        else if (ShiftDR) m_br = ScanIn;
      end else begin
        if (CaptureDR) begin
          load_chain({m_yr, m_xr, C, B, A});
        end else if (ShiftDR) begin
          void'(m_chain.pop_front());
          m_chain.push_back(ScanIn);
        end
        if (UpdateDR) m_ur = m_sr_old;
      end
      m_xr = m_a ^ m_b;
      m_yr = ~(m_xr | m_c);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("x", 32'(X), 32'(Mode ? m_ur[4*W-1:3*W] : m_xr));
      chk("y", 32'(Y), 32'(Mode ? m_ur[5*W-1:4*W] : m_yr));
      chk("scanout", 32'(ScanOut), 32'((BYP_EN && bypass) ? m_br : m_chain[0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic shift_out(output logic [N-1:0] got);
    got = {N{1'b0}};
    ShiftDR = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge Clk);
      got = {got[N-2:0], ScanOut};
      @(posedge Clk);
      #1;
    end
    ShiftDR = 1'b0;
  endtask

  task automatic shift_in(input logic [N-1:0] p);
    ShiftDR = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      ScanIn = p[i];
      cyc();
    end
    ShiftDR = 1'b0;
    ScanIn  = 1'b0;
  endtask

  logic [N-1:0] got;
  logic [2:0]   bgot;

  initial begin
    Reset = 1'b1; A = 4'b0000; B = 4'b0000; C = 4'b0000;
    Mode = 1'b0; CaptureDR = 1'b0; ShiftDR = 1'b0; UpdateDR = 1'b0;
    ScanIn = 1'b0; bypass = 1'b0;
    cyc(); cyc();
    chk_en = 1'b1;
    Reset  = 1'b0;
    @(negedge Clk);
    chk("reset_x", 32'(X), 32'h0);
    chk("reset_y", 32'(Y), 32'h0);
    chk("reset_scanout", 32'(ScanOut), 32'h0);
    @(posedge Clk); #1;

    // Normal path: 1 cycle latency.
    A = 4'b1010; B = 4'b0110; C = 4'b0001;
    cyc();
    @(negedge Clk);
    chk("normal_x", 32'(X), 32'h0000_000C);
    chk("normal_y", 32'(Y), 32'h0000_0002);
    @(posedge Clk); #1;

    // Capture then shift out: Y,X,C,B,A MSB first.
    CaptureDR = 1'b1; cyc(); CaptureDR = 1'b0;
    shift_out(got);
    chk("capture_chain", 32'(got), 32'h0002_C16A);

    // Load UR with a pattern, then enter test mode.
    shift_in(20'hF5036);
    UpdateDR = 1'b1; cyc(); UpdateDR = 1'b0;
    Mode = 1'b1;
    @(negedge Clk);
    chk("test_x", 32'(X), 32'h0000_0005);
    chk("test_y", 32'(Y), 32'h0000_000F);
    @(posedge Clk); #1;
    CaptureDR = 1'b1; cyc(); CaptureDR = 1'b0;
    shift_out(got);
    chk("test_core_chain", 32'(got), 32'h000A_516A);
    Mode = 1'b0;

    // Capture beats shift in the same cycle.
    cyc(); cyc();
    CaptureDR = 1'b1; ShiftDR = 1'b1; ScanIn = 1'b1;
    cyc();
    CaptureDR = 1'b0; ScanIn = 1'b0;
    shift_out(got);
    chk("priority_chain", 32'(got), 32'h0002_C16A);

    // Reset mid-shift clears the partial chain.
    ShiftDR = 1'b1; ScanIn = 1'b1;
    repeat (7) cyc();
    ShiftDR = 1'b0; ScanIn = 1'b0; Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    @(negedge Clk);
    chk("midreset_x", 32'(X), 32'h0);
    chk("midreset_y", 32'(Y), 32'h0);
    @(posedge Clk); #1;
    shift_out(got);
    chk("midreset_chain", 32'(got), 32'h0);

`ifdef XORNOR_BSCAN_BYPASS_EN
    // Bypass: one-cycle path through BR, with SR and UR frozen.
    shift_in(20'hF5036);
    UpdateDR = 1'b1; cyc(); UpdateDR = 1'b0;
    shift_in(20'h00000);
    Mode = 1'b1; bypass = 1'b1; ShiftDR = 1'b1; UpdateDR = 1'b1;
    bgot = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      ScanIn = (i != 1) ? 1'b1 : 1'b0;
      cyc();
      @(negedge Clk);
      bgot[i] = ScanOut;
      @(posedge Clk); #1;
      ShiftDR = 1'b1;
    end
    chk("bypass_seq", 32'(bgot), 32'h0000_0005);
    bypass = 1'b0; ShiftDR = 1'b0; UpdateDR = 1'b0; ScanIn = 1'b0;
    @(negedge Clk);
    chk("bypass_ur_x", 32'(X), 32'h0000_0005);
    chk("bypass_ur_y", 32'(Y), 32'h0000_000F);
    @(posedge Clk); #1;
    Mode = 1'b0;
`endif

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      Reset     = ($urandom_range(0, 63) == 0);
      Mode      = ($urandom_range(0, 3) == 0);
      CaptureDR = ($urandom_range(0, 7) == 0);
      ShiftDR   = ($urandom_range(0, 1) == 0);
      UpdateDR  = ($urandom_range(0, 7) == 0);
      ScanIn    = 1'($urandom);
      bypass    = ($urandom_range(0, 3) == 0);
      A = 4'($urandom); B = 4'($urandom); C = 4'($urandom);
      cyc();
    end
    @(negedge Clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
